// File: rtl/weight_stream_loader.sv
// Streams a weight segment into NUM_BANKS word-interleaved RAM banks, with a compute-side read port.
// Optional checksum verification is built when WEIGHT_STREAM_LOADER_CHECKSUM_EN is defined.
module weight_stream_loader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 20,
  parameter int NUM_BANKS  = 4,
  parameter int BANK_DEPTH = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_start,
  input  logic [ADDR_WIDTH-1:0] load_base,
  input  logic [ADDR_WIDTH-1:0] load_len,
  input  logic [15:0]           load_csum,
  input  logic                  load_abort,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic                  load_busy,
  output logic                  load_done,
  output logic                  load_error,
  output logic [1:0]            err_code,
  output logic [ADDR_WIDTH-1:0] words_loaded,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid
);

  localparam int TOTAL_DEPTH = NUM_BANKS * BANK_DEPTH;
  localparam int ROW_BITS    = (BANK_DEPTH > 1) ? $clog2(BANK_DEPTH) : 1;
  localparam int SEL_BITS    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int EXT_WIDTH   = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] NB_W    = ADDR_WIDTH'(NUM_BANKS);
  localparam logic [EXT_WIDTH-1:0]  TOTAL_W = EXT_WIDTH'(TOTAL_DEPTH);

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_RANGE = 2'b01;
  localparam logic [1:0] ERR_CSUM  = 2'b10;
  localparam logic [1:0] ERR_ABORT = 2'b11;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CHECK, S_DONE, S_ERROR} state_t;

  state_t                state_reg;
  logic                  s_ready_reg;
  logic                  busy_reg;
  logic                  done_reg;
  logic                  error_reg;
  logic [1:0]            err_code_reg;
  logic [ADDR_WIDTH-1:0] words_reg;
  logic [ADDR_WIDTH-1:0] len_reg;
  logic [ADDR_WIDTH-1:0] wr_addr_reg;

  logic                  beat;
  logic                  last_beat;
  logic                  csum_ok;
  logic [EXT_WIDTH-1:0]  end_addr;
  logic                  range_bad;
  logic [SEL_BITS-1:0]   wr_bank;
  logic [ROW_BITS-1:0]   wr_row;

  assign beat      = s_valid && s_ready_reg;
  assign last_beat = beat && (words_reg == len_reg - ADDR_WIDTH'(1));
  // One extra bit so base+len cannot wrap past the address space.
  assign end_addr  = {1'b0, load_base} + {1'b0, load_len};
  assign range_bad = end_addr > TOTAL_W;
  assign wr_bank   = SEL_BITS'(wr_addr_reg % NB_W);
  assign wr_row    = ROW_BITS'(wr_addr_reg / NB_W);

`ifdef WEIGHT_STREAM_LOADER_CHECKSUM_EN
  logic [15:0] csum_reg;
  logic [15:0] sum_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_reg  <= '0;
      csum_reg <= '0;
    end else if (load_start && (state_reg == S_IDLE || state_reg == S_DONE ||
                                state_reg == S_ERROR)) begin
      sum_reg  <= '0;
      csum_reg <= load_csum;
    end else if (beat) begin
      sum_reg <= sum_reg + 16'(s_data);
    end
  end

  assign csum_ok = (sum_reg == csum_reg);
`else
  logic unused_csum;
  assign unused_csum = ^load_csum;
  assign csum_ok     = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      s_ready_reg  <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      error_reg    <= 1'b0;
      err_code_reg <= ERR_NONE;
      words_reg    <= '0;
      len_reg      <= '0;
      wr_addr_reg  <= '0;
    end else begin
      if (beat) begin
        words_reg   <= words_reg + ADDR_WIDTH'(1);
        wr_addr_reg <= wr_addr_reg + ADDR_WIDTH'(1);
      end
      case (state_reg)
        S_IDLE, S_DONE, S_ERROR: begin
          if (load_start) begin
            done_reg     <= 1'b0;
            error_reg    <= 1'b0;
            err_code_reg <= ERR_NONE;
            words_reg    <= '0;
            len_reg      <= load_len;
            wr_addr_reg  <= load_base;
            if (range_bad) begin
              state_reg    <= S_ERROR;
              error_reg    <= 1'b1;
              err_code_reg <= ERR_RANGE;
            end else if (load_len == '0) begin
              state_reg <= S_CHECK;
              busy_reg  <= 1'b1;
            end else begin
              state_reg   <= S_LOAD;
              busy_reg    <= 1'b1;
              s_ready_reg <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          // Abort wins over completion; a beat in the abort cycle is still stored.
          if (load_abort) begin
            state_reg    <= S_ERROR;
            s_ready_reg  <= 1'b0;
            busy_reg     <= 1'b0;
            error_reg    <= 1'b1;
            err_code_reg <= ERR_ABORT;
          end else if (last_beat) begin
            state_reg   <= S_CHECK;
            s_ready_reg <= 1'b0;
          end
        end
        S_CHECK: begin
          busy_reg <= 1'b0;
          if (load_abort) begin
            state_reg    <= S_ERROR;
            error_reg    <= 1'b1;
            err_code_reg <= ERR_ABORT;
          end else if (csum_ok) begin
            state_reg <= S_DONE;
            done_reg  <= 1'b1;
          end else begin
            state_reg    <= S_ERROR;
            error_reg    <= 1'b1;
            err_code_reg <= ERR_CSUM;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  // Read side: every bank reads the same row, the registered bank select picks the word.
  logic [DATA_WIDTH-1:0] bank_q [NUM_BANKS];
  logic [SEL_BITS-1:0]   rd_bank;
  logic [ROW_BITS-1:0]   rd_row;
  logic                  rd_in_range;
  logic [SEL_BITS-1:0]   rd_sel_reg;
  logic                  rd_oor_reg;
  logic                  rd_valid_reg;

  assign rd_bank     = SEL_BITS'(rd_addr % NB_W);
  assign rd_row      = ROW_BITS'(rd_addr / NB_W);
  assign rd_in_range = {1'b0, rd_addr} < TOTAL_W;

  for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
    logic [DATA_WIDTH-1:0] mem [BANK_DEPTH];
    logic [DATA_WIDTH-1:0] q_reg;
    logic                  wr_en;

    assign wr_en = beat && (wr_bank == SEL_BITS'(gi));

    always_ff @(posedge clk) begin
      if (wr_en) begin
        mem[wr_row] <= s_data;
      end
    end

    // Read-before-write: a same-cycle write to this row returns the previous word.
    always_ff @(posedge clk) begin
      if (rst) begin
        q_reg <= '0;
      end else if (rd_en) begin
        q_reg <= mem[rd_row];
      end
    end

    assign bank_q[gi] = q_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_reg <= 1'b0;
      rd_oor_reg   <= 1'b0;
      rd_sel_reg   <= '0;
    end else begin
      rd_valid_reg <= rd_en;
      if (rd_en) begin
        rd_oor_reg <= !rd_in_range;
        rd_sel_reg <= rd_bank;
      end
    end
  end

  assign rd_data      = rd_oor_reg ? '0 : bank_q[rd_sel_reg];
  assign rd_valid     = rd_valid_reg;
  assign s_ready      = s_ready_reg;
  assign load_busy    = busy_reg;
  assign load_done    = done_reg;
  assign load_error   = error_reg;
  assign err_code     = err_code_reg;
  assign words_loaded = words_reg;

endmodule
